// File: rtl/mux_nway_reg.sv
// N-input registered multiplexer with a one-entry output register.
// Supports external select (MODE 0) or round-robin arbitration among valid inputs (MODE 1).
module mux_nway_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  // Handshake: a word moves on any rising edge where valid and ready are both 1
  // on the same interface; the producer holds data stable while valid && !ready.

  logic [WIDTH-1:0] in_word [NUM_IN];
  logic             accept;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;
  logic             transfer;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign in_word[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign accept = !out_valid || out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (MODE == 1) begin
      // Walk from rr_ptr upward with wraparound; the first valid input wins.
      for (int k = 0; k < NUM_IN; k++) begin
        scan_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (scan_sum >= (SEL_W+1)'(NUM_IN))
          scan_sum = scan_sum - (SEL_W+1)'(NUM_IN);
        scan_idx = scan_sum[SEL_W-1:0];
        if (!grant_valid && in_valid[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx;
        end
      end
    end else begin
      grant_valid = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
      grant_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (!reset && grant_valid)
      in_ready[grant_idx] = accept;
  end

  assign transfer = grant_valid && in_valid[grant_idx] && in_ready[grant_idx];
  assign rr_next  = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      data_out  <= in_word[grant_idx];
      out_src   <= grant_idx;
      out_valid <= 1'b1;
      if (MODE == 1)
        rr_ptr <= rr_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nway_reg.sv
// Directed bench for mux_nway_reg: external-select with N=4 and N=3, and round-robin with N=4.
module tb_mux_nway_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // MODE 0, N=4
  logic [127:0] d0;
  logic [3:0]   v0, r0;
  logic [1:0]   sel0, src0;
  logic [31:0]  do0;
  logic         ov0, ordy0;

  // MODE 0, N=3
  logic [95:0]  d3;
  logic [2:0]   v3, r3;
  logic [1:0]   sel3, src3;
  logic [31:0]  do3;
  logic         ov3, ordy3;

  // MODE 1, N=4
  logic [127:0] d1;
  logic [3:0]   v1, r1;
  logic [1:0]   sel1, src1;
  logic [31:0]  do1;
  logic         ov1, ordy1;

  mux_nway_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(0)) u_m0n4 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(sel0),
    .data_out(do0), .out_valid(ov0), .out_ready(ordy0), .out_src(src0));

  mux_nway_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .MODE(0)) u_m0n3 (
    .clk(clk), .reset(reset), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(sel3),
    .data_out(do3), .out_valid(ov3), .out_ready(ordy3), .out_src(src3));

  mux_nway_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(1)) u_m1n4 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(sel1),
    .data_out(do1), .out_valid(ov1), .out_ready(ordy1), .out_src(src1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input valid
    reset = 1'b1;
    d0 = {32'h0303_0303, 32'h0202_0202, 32'h0101_0101, 32'h0000_0000};
    d3 = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    d1 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    v0 = 4'b1111; v3 = 3'b111; v1 = 4'b1111;
    sel0 = 2'd2; sel3 = 2'd3; sel1 = 2'd0;
    ordy0 = 1'b1; ordy3 = 1'b1; ordy1 = 1'b1;
    tick();
    tick();
    chk("rst_ov0",  32'(ov0), 32'd0);
    chk("rst_do0",  do0,      32'd0);
    chk("rst_r0",   32'(r0),  32'd0);
    chk("rst_r1",   32'(r1),  32'd0);
    chk("rst_src1", 32'(src1), 32'd0);
    chk("rst_ov3",  32'(ov3), 32'd0);

    v0 = 4'b0000; v1 = 4'b0000;
    reset = 1'b0;

    // Select input 2 on the N=4 mux
    d0[2*32 +: 32] = 32'hDEAD_BEEF;
    v0 = 4'b0100;
    #1;
    chk("m0_r0_sel2", 32'(r0), 32'b0100);
    chk("n3_r3_oor",  32'(r3), 32'b000);
    tick();
    chk("m0_do_dead", do0,       32'hDEAD_BEEF);
    chk("m0_src_2",   32'(src0), 32'd2);
    chk("m0_ov_1",    32'(ov0),  32'd1);
    chk("n3_ov_oor",  32'(ov3),  32'd0);

    // Backpressure: output full, new source presented
    ordy0 = 1'b0;
    sel0 = 2'd1;
    d0[1*32 +: 32] = 32'h1234_5678;
    v0 = 4'b0010;
    #1;
    chk("bp_r0_zero", 32'(r0), 32'b0000);
    tick();
    chk("bp_do_hold",  do0,       32'hDEAD_BEEF);
    chk("bp_src_hold", 32'(src0), 32'd2);
    chk("bp_ov_hold",  32'(ov0),  32'd1);
    ordy0 = 1'b1;
    #1;
    chk("bp_r0_open", 32'(r0), 32'b0010);
    tick();
    chk("df_do_new",  do0,       32'h1234_5678);
    chk("df_src_new", 32'(src0), 32'd1);
    chk("df_ov_1",    32'(ov0),  32'd1);
    v0 = 4'b0000;
    tick();
    chk("drain_ov_0",    32'(ov0),  32'd0);
    chk("drain_do_hold", do0,       32'h1234_5678);
    chk("drain_src_hold",32'(src0), 32'd1);
    chk("n3_ov_still0",  32'(ov3),  32'd0);

    // N=3 with an in-range select still works
    sel3 = 2'd0;
    d3[0 +: 32] = 32'hA5A5_A5A5;
    #1;
    chk("n3_r3_sel0", 32'(r3), 32'b001);
    tick();
    chk("n3_do_a5",  do3,       32'hA5A5_A5A5);
    chk("n3_src_0",  32'(src3), 32'd0);
    sel3 = 2'd3;
    tick();
    chk("n3_ov_drop", 32'(ov3), 32'd0);

    // Round-robin with all inputs valid
    v1 = 4'b1111;
    #1;
    chk("rr_r1_first", 32'(r1), 32'b0001);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("rr_src_%0d", k), 32'(src1), 32'(k % 4));
      chk($sformatf("rr_do_%0d", k),  do1,       32'h1000_0000 + 32'(k % 4));
      chk($sformatf("rr_ov_%0d", k),  32'(ov1),  32'd1);
    end

    // rr_ptr is now 2: only input 1 valid is granted
    v1 = 4'b0010;
    #1;
    chk("rr_r1_only1", 32'(r1), 32'b0010);
    tick();
    chk("rr_src_only1", 32'(src1), 32'd1);
    chk("rr_do_only1",  do1,       32'h1000_0001);

    // rr_ptr is now 2: inputs 0,1 valid, scan 2,3,0 grants 0
    v1 = 4'b0011;
    #1;
    chk("rr_r1_wrap", 32'(r1), 32'b0001);
    tick();
    chk("rr_src_wrap", 32'(src1), 32'd0);

    // Reset while holding a word under backpressure
    ordy1 = 1'b0;
    v1 = 4'b1111;
    #1;
    chk("mid_r1_bp", 32'(r1), 32'b0000);
    reset = 1'b1;
    #1;
    chk("mid_r1_rst", 32'(r1), 32'b0000);
    tick();
    chk("mid_ov1",  32'(ov1),  32'd0);
    chk("mid_src1", 32'(src1), 32'd0);
    chk("mid_do1",  do1,       32'd0);
    reset = 1'b0;
    ordy1 = 1'b1;
    #1;
    chk("post_r1", 32'(r1), 32'b0001);
    tick();
    chk("post_src1", 32'(src1), 32'd0);
    chk("post_do1",  do1,       32'h1000_0000);
    chk("post_ov1",  32'(ov1),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
